// File: rtl/filter_window_buffer.sv
// Circular window buffer behind the band-pass IIR stage: rounds, shifts and saturates
// each filter sample to audio width, stores it, and announces a frame every HOP samples.
module filter_window_buffer #(
  parameter int IN_WIDTH  = 50,
  parameter int SHIFT     = 16,
  parameter int OUT_WIDTH = 16,
  parameter int WINDOW    = 1024,
  parameter int HOP       = 512
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic signed [IN_WIDTH-1:0]   sample_in,
  input  logic                         sample_valid_in,
  input  logic                         rd_en_in,
  input  logic [$clog2(WINDOW)-1:0]    rd_addr_in,
  output logic signed [OUT_WIDTH-1:0]  rd_data_out,
  output logic                         rd_valid_out,
  output logic                         frame_ready_out,
  input  logic                         frame_ack_in,
  output logic [$clog2(WINDOW)-1:0]    frame_base_out,
  output logic                         overrun_out
);

  localparam int AW    = $clog2(WINDOW);
  localparam int HOP_W = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int T_W   = IN_WIDTH + 1;

  localparam logic signed [T_W-1:0] ROUND   = T_W'(64'd1 << (SHIFT - 1));
  localparam logic signed [T_W-1:0] SAT_MAX = T_W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [T_W-1:0] SAT_MIN = -SAT_MAX - T_W'(1);
  localparam logic [AW-1:0]         LAST_PTR = AW'(WINDOW - 1);
  localparam logic [HOP_W-1:0]      LAST_HOP = HOP_W'(HOP - 1);

  // ---------------------------------------------------------------------------
  // Scaling: round-half-up, arithmetic shift, saturate
  // ---------------------------------------------------------------------------
  logic signed [T_W-1:0]       t_sum;
  logic signed [T_W-1:0]       t_shift;
  logic signed [OUT_WIDTH-1:0] scaled;

  // NOTE: every signal driven in always_comb gets a value on all paths (defaults
  // first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    t_sum   = $signed({sample_in[IN_WIDTH-1], sample_in}) + ROUND;
    t_shift = t_sum >>> SHIFT;
    scaled  = t_shift[OUT_WIDTH-1:0];
    if (t_shift > SAT_MAX) begin
      scaled = SAT_MAX[OUT_WIDTH-1:0];
    end else if (t_shift < SAT_MIN) begin
      scaled = SAT_MIN[OUT_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer, fill tracking and frame generation
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    wr_ptr_q,      wr_ptr_d;
  logic [HOP_W-1:0] hop_cnt_q,     hop_cnt_d;
  logic             filled_q,      filled_d;
  logic             frame_ready_q, frame_ready_d;
  logic [AW-1:0]    frame_base_q,  frame_base_d;
  logic             overrun_q,     overrun_d;
  logic             boundary;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    hop_cnt_d     = hop_cnt_q;
    filled_d      = filled_q;
    frame_ready_d = frame_ready_q;
    frame_base_d  = frame_base_q;
    overrun_d     = overrun_q;
    boundary      = 1'b0;

    if (sample_valid_in) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (!filled_q) begin
        // Pointer starts at 0 after reset, so slot WINDOW-1 is the WINDOW-th write.
        if (wr_ptr_q == LAST_PTR) begin
          filled_d = 1'b1;
          boundary = 1'b1;
        end
      end else if (hop_cnt_q == LAST_HOP) begin
        hop_cnt_d = '0;
        boundary  = 1'b1;
      end else begin
        hop_cnt_d = hop_cnt_q + HOP_W'(1);
      end
    end

    // A boundary beats a simultaneous ack; an ack in that cycle still excuses the overrun.
    if (boundary) begin
      frame_ready_d = 1'b1;
      frame_base_d  = wr_ptr_q + AW'(1);
      if (frame_ready_q && !frame_ack_in) begin
        overrun_d = 1'b1;
      end
    end else if (frame_ack_in) begin
      frame_ready_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q      <= '0;
      hop_cnt_q     <= '0;
      filled_q      <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_base_q  <= '0;
      overrun_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      hop_cnt_q     <= hop_cnt_d;
      filled_q      <= filled_d;
      frame_ready_q <= frame_ready_d;
      frame_base_q  <= frame_base_d;
      overrun_q     <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample memory: one write port, one registered read port (read-first)
  // ---------------------------------------------------------------------------
  logic signed [OUT_WIDTH-1:0] mem [WINDOW];
  logic [AW-1:0]               rd_phys;
  logic signed [OUT_WIDTH-1:0] rd_data_q;
  logic                        rd_valid_q, rd_valid_d;

  assign rd_phys    = frame_base_q + rd_addr_in;
  assign rd_valid_d = rd_en_in;

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // pointers and flags that give its contents meaning are reset.
  always_ff @(posedge clk_in) begin
    if (sample_valid_in) begin
      mem[wr_ptr_q] <= scaled;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      if (rd_en_in) begin
        rd_data_q <= mem[rd_phys];
      end
    end
  end

  assign rd_data_out     = rd_data_q;
  assign rd_valid_out    = rd_valid_q;
  assign frame_ready_out = frame_ready_q;
  assign frame_base_out  = frame_base_q;
  assign overrun_out     = overrun_q;

endmodule

// File: doc/filter_window_buffer.md
Name: filter_window_buffer

Overview:
- Sits directly downstream of the band-pass IIR filter stage and consumes its wide fixed-point output.
- Each sample is rounded, shifted and saturated back to audio width, then written into a circular window buffer.
- Every HOP samples, once the buffer is full, it raises a frame-ready flag; the pitch-detection stage then reads WINDOW samples through a random-access, 1-cycle-latency read port.

Parameters:
- IN_WIDTH, 50, width of the signed filter output (32 data + 18 coefficient bits).
- SHIFT, 16, fractional bits dropped from the filter output.
- OUT_WIDTH, 16, signed width of the stored samples.
- WINDOW, 1024, frame length in samples; power of 2, ≥ 4.
- HOP, 512, new samples between frames; 1 ≤ HOP ≤ WINDOW.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset.
- sample_in  in  IN_WIDTH  signed filtered sample.
- sample_valid_in  in  1  one-cycle strobe; sample_in is valid this cycle.
- rd_en_in  in  1  read request.
- rd_addr_in  in  $clog2(WINDOW)  frame-relative index; 0 is the oldest sample.
- rd_data_out  out  OUT_WIDTH  signed sample read from the buffer.
- rd_valid_out  out  1  rd_data_out valid; asserts 1 cycle after rd_en_in.
- frame_ready_out  out  1  a complete frame is available.
- frame_ack_in  in  1  consumer is done with the current frame.
- frame_base_out  out  $clog2(WINDOW)  physical address of the oldest sample in the frame (debug/visibility).
- overrun_out  out  1  sticky: a frame boundary occurred while the previous frame was not acked.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst_in, clock is clk_in.
- Reset values: rd_data_out=0, rd_valid_out=0, frame_ready_out=0, frame_base_out=0, overrun_out=0.
- Reset also clears the write pointer, hop counter and filled flag. Memory contents are not cleared.
- Reset mid-frame drops any pending frame; the next frame requires WINDOW fresh samples.
- Scaling (combinational, same cycle as sample_valid_in):
  - t = sign-extend(sample_in) to IN_WIDTH+1 bits, plus 2^(SHIFT-1).
  - s = t >>> SHIFT (arithmetic shift; round-half-up).
  - If s > 2^(OUT_WIDTH-1)-1, clamp to that value; if s < -2^(OUT_WIDTH-1), clamp to that value.
- Write path:
  - On sample_valid_in: mem[wr_ptr] <= s; wr_ptr <= wr_ptr+1, wrapping modulo WINDOW.
  - Writes occur regardless of frame state; there is no backpressure.
- Frame generation:
  - filled is set on the write that completes WINDOW total samples since reset.
  - hop_cnt counts valid writes 0..HOP-1 and wraps; it starts counting only after filled.
  - A frame boundary occurs on the valid write that sets filled, and on every HOP-th valid write thereafter.
  - At a boundary, next cycle: frame_base_out <= wr_ptr+1 (oldest sample) and frame_ready_out <= 1.
  - If frame_ready_out is already 1 at the boundary, overrun_out <= 1 (sticky until reset) and frame_base_out still updates.
  - frame_ack_in with no boundary in the same cycle: frame_ready_out <= 0 next cycle.
  - frame_ack_in and a boundary in the same cycle: the boundary wins; frame_ready_out stays 1, frame_base_out updates, no overrun.
  - frame_ack_in while frame_ready_out=0 is ignored.
- Read port:
  - rd_en_in in cycle N → rd_data_out = mem[(frame_base_out + rd_addr_in) mod WINDOW] in cycle N+1, with rd_valid_out=1 in N+1.
  - rd_valid_out is 0 otherwise; rd_data_out holds its last value.
  - Reads are allowed at any time, but data is meaningful only while frame_ready_out=1.
  - A read of the address being written in the same cycle returns the old data (read-first).
- Consumer contract: the consumer must read and ack within HOP sample periods, or the oldest frame samples are overwritten; overrun_out flags this violation.
- Memory: single write port plus one read port, inferable as block RAM.

Test Plan:
- Scaling/rounding: sample_in = 0x18000 (1.5) → stored 2; 0x17FFF → 1; -0x18000 → -1; 0x7FFF_0000_0000 → saturates to 32767; most-negative input → -32768.
- Fill and first frame, WINDOW=8, HOP=4: write values 1..8 → frame_ready_out rises the cycle after the 8th write with frame_base_out=0; reading addresses 0..7 returns 1..8 with 1-cycle latency.
- Hop and wrap: ack, then write 9..12 → frame_ready_out rises again with frame_base_out=4; reads of addresses 0..7 return 5..12.
- Overrun: no ack, write 4 more samples → overrun_out=1, frame_ready_out stays 1, frame_base_out=0, reads return 9..16. Separately, ack on the same cycle as a boundary → frame_ready_out stays 1 and overrun_out stays 0.
- Reset mid-operation: assert rst_in after 6 writes → all outputs 0; a following 7 writes give no frame; the 8th post-reset write raises frame_ready_out.
- Gapped valids: random idle gaps between sample_valid_in strobes → frame timing counts only valid writes, and read data matches a reference model.
